// File: rtl/aftab_daru_multibeat.sv
`default_nettype none
// ===========================================================================
// aftab_daru_multibeat: assembles 1/2/4-byte loads from MEM_BYTES-wide beats
// and sign/zero extends them; optional alignment check. Revision 1.0
// ===========================================================================
module aftab_daru_multibeat #(
  parameter int SIZE      = 32,
  parameter int MEM_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startDARU,
  input  logic                   memReady,
  input  logic                   dataInstrBar,
  input  logic                   checkMisalignedDARU,
  input  logic                   signedLoad,
  input  logic [SIZE-1:0]        addrIn,
  input  logic [1:0]             nBytes,
  input  logic [8*MEM_BYTES-1:0] memData,
  output logic                   readMem,
  output logic [SIZE-1:0]        addrOut,
  output logic [SIZE-1:0]        dataOut,
  output logic                   completeDARU,
  output logic                   busy,
  output logic                   instrMisalignedFlag,
  output logic                   loadMisalignedFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      beat_q, beat_d;
  logic [1:0]      nbytes_q, nbytes_d;
  logic            signed_q, signed_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            iflag_q, iflag_d;
  logic            lflag_q, lflag_d;
  logic            misaligned;
  logic [2:0]      acc_bytes;
  logic            last_beat;

  assign misaligned = checkMisalignedDARU &
                      (((nBytes == 2'b01) & addrIn[0]) |
                       (nBytes[1] & (addrIn[1:0] != 2'b00)));

  always_comb begin
    acc_bytes = 3'd4;
    if (nbytes_q == 2'b00)      acc_bytes = 3'd1;
    else if (nbytes_q == 2'b01) acc_bytes = 3'd2;
  end

  assign last_beat = (int'(beat_q) == (int'(acc_bytes) - 1) / MEM_BYTES);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nbytes_d = nbytes_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    iflag_d  = iflag_q;
    lflag_d  = lflag_q;
    case (state_q)
      IDLE: begin
        if (startDARU) begin
          nbytes_d = nBytes;
          signed_d = signedLoad;
          data_d   = '0;
          beat_d   = '0;
          iflag_d  = 1'b0;
          lflag_d  = 1'b0;
          if (misaligned) begin
            lflag_d = dataInstrBar;
            iflag_d = ~dataInstrBar;
            state_d = DONE;
          end else begin
            addr_d  = addrIn;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (memReady) begin
          // Result byte b comes from beat b/MEM_BYTES, lane b%MEM_BYTES.
          for (int b = 0; b < 4; b++) begin
            if ((b * 8 + 8 <= SIZE) && (b < int'(acc_bytes)) &&
                (int'(beat_q) == b / MEM_BYTES)) begin
              data_d[b*8 +: 8] = memData[(b % MEM_BYTES)*8 +: 8];
            end
          end
          beat_d = beat_q + 3'd1;
          if (last_beat) begin
            if (acc_bytes == 3'd1)
              data_d[SIZE-1:8] = {(SIZE-8){signed_q & data_d[7]}};
            else if (acc_bytes == 3'd2)
              data_d[SIZE-1:16] = {(SIZE-16){signed_q & data_d[15]}};
            state_d = DONE;
          end else begin
            addr_d = addr_q + SIZE'(MEM_BYTES);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      nbytes_q <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      iflag_q  <= 1'b0;
      lflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nbytes_q <= nbytes_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      iflag_q  <= iflag_d;
      lflag_q  <= lflag_d;
    end
  end

  assign readMem             = (state_q == READ);
  assign busy                = (state_q != IDLE);
  assign completeDARU        = (state_q == DONE);
  assign addrOut             = addr_q;
  assign dataOut             = data_q;
  assign instrMisalignedFlag = iflag_q;
  assign loadMisalignedFlag  = lflag_q;

endmodule
`default_nettype wire

// File: tb/tb_aftab_daru_multibeat.sv
`default_nettype none
// tb_aftab_daru_multibeat: directed vectors on a 1-byte-beat instance (a)
// and a 2-byte-beat instance (b) backed by a small byte memory.
module tb_aftab_daru_multibeat;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, memReady, dib, chk, sgn;
  logic [31:0] addrIn;
  logic [1:0]  nBytes;
  logic [7:0]  md_a;
  logic [15:0] md_b;
  logic        rd_a, cmp_a, busy_a, if_a, lf_a;
  logic        rd_b, cmp_b, busy_b, if_b, lf_b;
  logic [31:0] ao_a, do_a, ao_b, do_b;
  logic [7:0]  mem [0:1023];
  logic [31:0] addr_log [0:7];
  int          n_log;
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_a = 0;
  int          done_b = 0;
  int          lat, snap;
  bit          rd_seen;

  always #5 clk = ~clk;

  assign md_a = mem[ao_a[9:0]];
  assign md_b = {mem[ao_b[9:0] + 10'd1], mem[ao_b[9:0]]};

  always @(posedge clk) begin
    if (cmp_a) done_a <= done_a + 1;
    if (cmp_b) done_b <= done_b + 1;
  end

  aftab_daru_multibeat #(.SIZE(32), .MEM_BYTES(1)) u_a (
    .clk(clk), .rst(rst), .startDARU(start_a), .memReady(memReady),
    .dataInstrBar(dib), .checkMisalignedDARU(chk), .signedLoad(sgn),
    .addrIn(addrIn), .nBytes(nBytes), .memData(md_a), .readMem(rd_a),
    .addrOut(ao_a), .dataOut(do_a), .completeDARU(cmp_a), .busy(busy_a),
    .instrMisalignedFlag(if_a), .loadMisalignedFlag(lf_a));

  aftab_daru_multibeat #(.SIZE(32), .MEM_BYTES(2)) u_b (
    .clk(clk), .rst(rst), .startDARU(start_b), .memReady(memReady),
    .dataInstrBar(dib), .checkMisalignedDARU(chk), .signedLoad(sgn),
    .addrIn(addrIn), .nBytes(nBytes), .memData(md_b), .readMem(rd_b),
    .addrOut(ao_b), .dataOut(do_b), .completeDARU(cmp_b), .busy(busy_b),
    .instrMisalignedFlag(if_b), .loadMisalignedFlag(lf_b));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_zero_a(input string p);
    check_value({p, "_rd"},   32'(rd_a),   32'd0);
    check_value({p, "_cmp"},  32'(cmp_a),  32'd0);
    check_value({p, "_busy"}, 32'(busy_a), 32'd0);
    check_value({p, "_if"},   32'(if_a),   32'd0);
    check_value({p, "_lf"},   32'(lf_a),   32'd0);
    check_value({p, "_data"}, do_a,        32'd0);
    check_value({p, "_addr"}, ao_a,        32'd0);
  endtask

  // Called on a negedge; returns on the first negedge back in IDLE.
  task automatic run(input int which, input logic [31:0] a, input logic [1:0] nb,
                     input logic s, input logic d, input logic c, input int stall,
                     input bit poke, output int lat_o, output bit rd_o);
    logic        rd, cp;
    logic [31:0] ao;
    addrIn = a; nBytes = nb; sgn = s; dib = d; chk = c;
    memReady = (stall == 0);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    n_log = 0; lat_o = 0; rd_o = 1'b0;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      rd = (which == 0) ? rd_a : rd_b;
      cp = (which == 0) ? cmp_a : cmp_b;
      ao = (which == 0) ? ao_a : ao_b;
      if (rd) rd_o = 1'b1;
      if (cp) begin
        lat_o = cyc;
        break;
      end
      memReady = (cyc > stall);
      if (cyc <= stall) begin
        check_value("stall_addr", ao, a);
        check_value("stall_rd", 32'(rd), 32'd1);
      end
      if (rd && memReady && n_log < 8) begin
        addr_log[n_log] = ao;
        n_log++;
      end
      if (poke) begin
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; memReady = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    mem[10'h180] = 8'h80;
    mem[10'h190] = 8'h34; mem[10'h191] = 8'h92; mem[10'h192] = 8'hAB;
    mem[10'h200] = 8'hA1; mem[10'h201] = 8'hB2; mem[10'h202] = 8'hC3; mem[10'h203] = 8'hD4;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; memReady = 1'b1;
    dib = 1'b1; chk = 1'b0; sgn = 1'b0; addrIn = 32'h0; nBytes = 2'b00;

    repeat (2) @(negedge clk);
    check_zero_a("rst");
    check_value("rst_b_busy", 32'(busy_b), 32'd0);
    check_value("rst_b_rd",   32'(rd_b),   32'd0);

    // Word load, MEM_BYTES=1, start on the first edge after reset release
    rst = 1'b1;
    run(0, 32'h100, 2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("w1_lat",  32'(lat), 32'd5);
    check_value("w1_data", do_a, 32'h44332211);
    check_value("w1_nlog", 32'(n_log), 32'd4);
    for (int k = 0; k < 4; k++) check_value("w1_addr", addr_log[k], 32'h100 + 32'(k));
    check_value("w1_addr_hold", ao_a, 32'h103);
    check_value("w1_lf", 32'(lf_a), 32'd0);

    run(0, 32'h180, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b0, lat, rd_seen);
    check_value("sb_lat",  32'(lat), 32'd2);
    check_value("sb_data", do_a, 32'hFFFFFF80);
    run(0, 32'h180, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0, lat, rd_seen);
    check_value("ub_data", do_a, 32'h00000080);

    // Misaligned halfword with the check disabled still reads
    run(0, 32'h101, 2'b01, 1'b0, 1'b1, 1'b0, 0, 1'b0, lat, rd_seen);
    check_value("uh_lat",  32'(lat), 32'd3);
    check_value("uh_data", do_a, 32'h00003322);

    // Misaligned loads on MEM_BYTES=2
    run(1, 32'h103, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("ml_lat",  32'(lat), 32'd1);
    check_value("ml_rd",   32'(rd_seen), 32'd0);
    check_value("ml_lf",   32'(lf_b), 32'd1);
    check_value("ml_if",   32'(if_b), 32'd0);
    check_value("ml_data", do_b, 32'd0);
    repeat (3) @(negedge clk);
    check_value("ml_lf_hold", 32'(lf_b), 32'd1);
    check_value("ml_cmp_low", 32'(cmp_b), 32'd0);
    run(1, 32'h103, 2'b01, 1'b0, 1'b0, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("mi_if", 32'(if_b), 32'd1);
    check_value("mi_lf", 32'(lf_b), 32'd0);

    // Word load with beat 0 stalled for three cycles
    run(1, 32'h200, 2'b11, 1'b0, 1'b1, 1'b1, 3, 1'b0, lat, rd_seen);
    check_value("st_lat",  32'(lat), 32'd6);
    check_value("st_data", do_b, 32'hD4C3B2A1);
    check_value("st_nlog", 32'(n_log), 32'd2);
    check_value("st_a0",   addr_log[0], 32'h200);
    check_value("st_a1",   addr_log[1], 32'h202);

    run(1, 32'h190, 2'b01, 1'b1, 1'b1, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("sh_lat",  32'(lat), 32'd2);
    check_value("sh_data", do_b, 32'hFFFF9234);
    run(1, 32'h191, 2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("bl_data", do_b, 32'h00000092);

    run(0, 32'h102, 2'b10, 1'b0, 1'b0, 1'b1, 0, 1'b0, lat, rd_seen);
    check_value("mw_if",  32'(if_a), 32'd1);
    check_value("mw_lat", 32'(lat), 32'd1);

    // startDARU held through READ and DONE
    snap = done_a;
    run(0, 32'h100, 2'b10, 1'b0, 1'b1, 1'b0, 0, 1'b1, lat, rd_seen);
    repeat (2) @(negedge clk);
    check_value("pk_lat",   32'(lat), 32'd5);
    check_value("pk_data",  do_a, 32'h44332211);
    check_value("pk_busy",  32'(busy_a), 32'd0);
    check_value("pk_count", 32'(done_a - snap), 32'd1);

    // Reset during beat 2 of a 4-beat load
    snap = done_a;
    addrIn = 32'h100; nBytes = 2'b10; sgn = 1'b0; dib = 1'b1; chk = 1'b0;
    memReady = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    check_value("ab_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b0;
    #1;
    check_zero_a("ab");
    @(negedge clk);
    rst = 1'b1;
    check_value("ab_count", 32'(done_a - snap), 32'd0);
    run(0, 32'h180, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0, lat, rd_seen);
    check_value("ab_lat",  32'(lat), 32'd2);
    check_value("ab_data", do_a, 32'h00000080);

    repeat (2) @(negedge clk);
    check_value("tot_a", 32'(done_a), 32'd7);
    check_value("tot_b", 32'(done_b), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
